// File: rtl/riffa_ahir_pkg.sv
// Shared types and constant helpers for the AHIR <-> RIFFA bridge blocks.
package riffa_ahir_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, PAD} framer_state_t;

  localparam int WORD_BITS        = 32;
  localparam int C_PCI_DATA_WIDTH = 32;
  localparam int NUM_WORDS        = C_PCI_DATA_WIDTH / WORD_BITS;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int num_words(input int width);
    return width / WORD_BITS;
  endfunction

endpackage

// File: rtl/ahir_tx_fifo.sv
// First-word-fall-through sync FIFO; head is valid whenever empty is low.
module ahir_tx_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  import riffa_ahir_pkg::*;

  localparam int AW = cnt_width(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // A push while full is refused even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ahir_tx_framer.sv
// Frames AHIR core result beats into fixed FRAME_BEATS frames, padding stalled frames.
// Define AHIR_TX_FRAMER_FLUSH_EN to add a flush input that pads as soon as the FIFO drains.
module ahir_tx_framer #(
  parameter int          C_PCI_DATA_WIDTH = 32,
  parameter int          FRAME_BEATS      = 120,
  parameter int          FIFO_DEPTH       = 8,
  parameter int          TIMEOUT_CYCLES   = 1024,
  parameter logic [31:0] PAD_WORD         = 32'h0
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [C_PCI_DATA_WIDTH-1:0] core_pipe_write_data,
  input  logic                        core_pipe_write_req,
  output logic                        core_pipe_write_ack,
  output logic [C_PCI_DATA_WIDTH-1:0] out_data_pipe_read_data,
  output logic                        out_data_pipe_read_ack,
  input  logic                        out_data_pipe_read_req,
`ifdef AHIR_TX_FRAMER_FLUSH_EN
  input  logic                        flush,
`endif
  output logic                        frame_done,
  output logic                        pad_active
);
  import riffa_ahir_pkg::*;

  localparam int NW = num_words(C_PCI_DATA_WIDTH);
  localparam int BW = cnt_width(FRAME_BEATS);
  localparam int SW = cnt_width(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_BEATS - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [C_PCI_DATA_WIDTH-1:0] PAD_BEAT = {NW{PAD_WORD}};

  framer_state_t state, state_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  logic [SW-1:0] stall_cnt, stall_nxt;
  logic [C_PCI_DATA_WIDTH-1:0] fifo_head;
  logic fifo_full, fifo_empty;
  logic xfer, last, flush_hit;

  ahir_tx_fifo #(.W(C_PCI_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (core_pipe_write_req),
    .push_data (core_pipe_write_data),
    .pop       (xfer && (state != PAD)),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign core_pipe_write_ack    = !fifo_full;
  assign out_data_pipe_read_ack = (state == PAD) || !fifo_empty;
  // Gate the head so the bus reads zero rather than stale storage when nothing is offered.
  assign out_data_pipe_read_data = (state == PAD) ? PAD_BEAT :
                                   (fifo_empty ? '0 : fifo_head);
  assign pad_active = (state == PAD);
  assign xfer       = out_data_pipe_read_ack && out_data_pipe_read_req;
  assign last       = (beat_cnt == LAST_BEAT);

`ifdef AHIR_TX_FRAMER_FLUSH_EN
  logic flush_pend;
  assign flush_hit = flush || flush_pend;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) flush_pend <= 1'b0;
    else        flush_pend <= (state_nxt == STREAM) && (flush_pend || (state == STREAM && flush));
  end
`else
  assign flush_hit = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat_cnt;
    stall_nxt  = stall_cnt;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        stall_nxt = '0;
        if (xfer && !last) state_nxt = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          stall_nxt = '0;
        end else if (fifo_empty) begin
          if (flush_hit || (TIMEOUT_CYCLES != 0 && stall_cnt == STALL_LAST)) begin
            state_nxt = PAD;
            stall_nxt = '0;
          end else if (TIMEOUT_CYCLES != 0) begin
            stall_nxt = stall_cnt + 1'b1;
          end
        end
      end
      PAD:     stall_nxt = '0;
      default: state_nxt = IDLE;
    endcase
    // Beat counting is identical in every state; the last beat always closes the frame.
    if (xfer) begin
      if (last) begin
        frame_done = 1'b1;
        beat_nxt   = '0;
        state_nxt  = IDLE;
      end else begin
        beat_nxt = beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_nxt;
      stall_cnt <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_ahir_tx_framer.sv
// Directed bench: instance 0 pads after 16 stall cycles, instance 1 never pads.
module tb_ahir_tx_framer;

  localparam logic [31:0] PADV = 32'hA5A5_5A5A;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] c_data [2];
  logic        c_req  [2];
  logic        c_ack  [2];
  logic [31:0] o_data [2];
  logic        o_ack  [2];
  logic        o_req  [2];
  logic        o_fd   [2];
  logic        o_pa   [2];
  logic        flush_a;
  int          nchk = 0;
  int          npass = 0;

  always #5 CLK = ~CLK;

  ahir_tx_framer #(.TIMEOUT_CYCLES(16), .PAD_WORD(PADV)) dut0 (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .core_pipe_write_data    (c_data[0]),
    .core_pipe_write_req     (c_req[0]),
    .core_pipe_write_ack     (c_ack[0]),
    .out_data_pipe_read_data (o_data[0]),
    .out_data_pipe_read_ack  (o_ack[0]),
    .out_data_pipe_read_req  (o_req[0]),
`ifdef AHIR_TX_FRAMER_FLUSH_EN
    .flush                   (flush_a),
`endif
    .frame_done              (o_fd[0]),
    .pad_active              (o_pa[0])
  );

  ahir_tx_framer #(.TIMEOUT_CYCLES(0), .PAD_WORD(PADV)) dut1 (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .core_pipe_write_data    (c_data[1]),
    .core_pipe_write_req     (c_req[1]),
    .core_pipe_write_ack     (c_ack[1]),
    .out_data_pipe_read_data (o_data[1]),
    .out_data_pipe_read_ack  (o_ack[1]),
    .out_data_pipe_read_req  (o_req[1]),
`ifdef AHIR_TX_FRAMER_FLUSH_EN
    .flush                   (1'b0),
`endif
    .frame_done              (o_fd[1]),
    .pad_active              (o_pa[1])
  );

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic step(input int s, input logic push, input logic [31:0] pd,
                      input logic rq, input logic fl);
    @(negedge CLK);
    c_req[s]  = push;
    c_data[s] = pd;
    o_req[s]  = rq;
    flush_a   = (s == 0) ? fl : 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    nchk++; if (c_ack[0] !== 1'b1) $display("FAIL reset_core_ack got %b want 1", c_ack[0]); else npass++;
    nchk++; if (o_ack[0] !== 1'b0) $display("FAIL reset_out_ack got %b want 0", o_ack[0]); else npass++;
    nchk++; if (o_data[0] !== 32'h0) $display("FAIL reset_data got %h want 0", o_data[0]); else npass++;
    nchk++; if (o_fd[0] !== 1'b0 || o_pa[0] !== 1'b0)
      $display("FAIL reset_flags got fd=%b pad=%b want 0 0", o_fd[0], o_pa[0]); else npass++;
    @(negedge CLK);
    RST_N = 1'b1;
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    nchk++; if (o_ack[0] !== 1'b0 || c_ack[0] !== 1'b1)
      $display("FAIL post_reset_idle got ack=%b core_ack=%b want 0 1", o_ack[0], c_ack[0]); else npass++;
  endtask

  task automatic test_stream();
    int sent = 0, got = 0, cyc = 0;
    bit pad_seen = 0, stray = 0;
    while (got < 120 && cyc < 600) begin
      step(0, sent < 120, 32'h1000 + sent, 1'b1, 1'b0);
      if (cyc == 0) begin
        nchk++; if (o_ack[0] !== 1'b0) $display("FAIL latency_empty got %b want 0", o_ack[0]); else npass++;
      end
      if (cyc == 1) begin
        nchk++; if (o_ack[0] !== 1'b1) $display("FAIL latency_one got %b want 1", o_ack[0]); else npass++;
      end
      if (c_req[0] && c_ack[0]) sent++;
      if (o_ack[0] === 1'b1) begin
        nchk++;
        if (o_data[0] !== 32'h1000 + got || o_fd[0] !== (got == 119))
          $display("FAIL stream_beat %0d got %h fd=%b want %h fd=%b", got, o_data[0], o_fd[0], 32'h1000 + got, got == 119);
        else npass++;
        got++;
      end else if (o_fd[0] === 1'b1) stray = 1;
      if (o_pa[0] === 1'b1) pad_seen = 1;
      cyc++;
    end
    nchk++; if (got != 120) $display("FAIL stream_count got %0d want 120", got); else npass++;
    nchk++; if (pad_seen || stray) $display("FAIL stream_flags got pad=%b stray_fd=%b want 0 0", pad_seen, stray); else npass++;
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, acc = 0, cyc = 0;
    bit stable = 1;
    for (int c = 0; c < 20; c++) begin
      step(0, 1'b1, 32'h2000 + sent, 1'b0, 1'b0);
      if (c_ack[0]) begin sent++; acc++; end
      if (o_ack[0] && o_data[0] !== 32'h2000) stable = 0;
    end
    nchk++; if (acc != 8) $display("FAIL bp_accepts got %0d want 8", acc); else npass++;
    nchk++; if (c_ack[0] !== 1'b0) $display("FAIL bp_full_ack got %b want 0", c_ack[0]); else npass++;
    nchk++; if (!stable || o_data[0] !== 32'h2000 || o_ack[0] !== 1'b1)
      $display("FAIL bp_hold got %h ack=%b want 00002000 ack=1", o_data[0], o_ack[0]); else npass++;
    while (got < 120 && cyc < 800) begin
      step(0, sent < 120, 32'h2000 + sent, 1'b1, 1'b0);
      if (c_req[0] && c_ack[0]) sent++;
      if (o_ack[0] === 1'b1) begin
        nchk++;
        if (o_data[0] !== 32'h2000 + got || o_fd[0] !== (got == 119))
          $display("FAIL bp_beat %0d got %h fd=%b want %h", got, o_data[0], o_fd[0], 32'h2000 + got);
        else npass++;
        got++;
      end
      cyc++;
    end
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    nchk++; if (got != 120 || o_ack[0] !== 1'b0)
      $display("FAIL bp_count got %0d extra_ack=%b want 120 0", got, o_ack[0]); else npass++;
  endtask

  task automatic test_timeout();
    int sent = 0, got = 0, cyc = 0, gap = 0, npad = 0, cnt = 1;
    bit pushed = 0;
    while (got < 50 && cyc < 300) begin
      step(0, sent < 50, 32'h3000 + sent, 1'b1, 1'b0);
      if (c_req[0] && c_ack[0]) sent++;
      if (o_ack[0] === 1'b1) begin
        nchk++;
        if (o_data[0] !== 32'h3000 + got) $display("FAIL to_data %0d got %h want %h", got, o_data[0], 32'h3000 + got);
        else npass++;
        got++;
      end
      cyc++;
    end
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    while (o_ack[0] !== 1'b1 && gap < 100) begin
      gap++;
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    nchk++; if (gap != 16) $display("FAIL to_gap got %0d want 16", gap); else npass++;
    nchk++; if (o_pa[0] !== 1'b1 || o_data[0] !== PADV)
      $display("FAIL to_pad_start got pad=%b data=%h want 1 %h", o_pa[0], o_data[0], PADV); else npass++;
    npad = 1;
    cyc = 0;
    while (o_fd[0] !== 1'b1 && cyc < 200) begin
      step(0, !pushed, 32'h3100, 1'b1, 1'b0);
      if (c_req[0] && c_ack[0]) pushed = 1;
      if (o_ack[0] === 1'b1) begin
        npad++;
        if (o_data[0] !== PADV || o_pa[0] !== 1'b1) begin
          nchk++; $display("FAIL to_pad_beat %0d got %h pad=%b want %h 1", npad, o_data[0], o_pa[0], PADV);
        end
      end
      cyc++;
    end
    nchk++; if (npad != 70) $display("FAIL to_pad_count got %0d want 70", npad); else npass++;
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    nchk++; if (o_ack[0] !== 1'b1 || o_data[0] !== 32'h3100 || o_pa[0] !== 1'b0)
      $display("FAIL to_next_frame got ack=%b %h pad=%b want 1 00003100 0", o_ack[0], o_data[0], o_pa[0]); else npass++;
    cyc = 0;
    while (cyc < 400) begin
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (o_ack[0] === 1'b1) cnt++;
      if (o_fd[0] === 1'b1) break;
      cyc++;
    end
    nchk++; if (cnt != 120) $display("FAIL to_next_len got %0d want 120", cnt); else npass++;
  endtask

  task automatic test_reset_mid();
    int sent = 0, got = 0, cyc = 0;
    while (got < 60 && cyc < 300) begin
      step(0, sent < 60, 32'h4000 + sent, 1'b1, 1'b0);
      if (c_req[0] && c_ack[0]) sent++;
      if (o_ack[0] === 1'b1) got++;
      cyc++;
    end
    for (int i = 0; i < 5; i++) step(0, 1'b1, 32'h4040 + i, 1'b0, 1'b0);
    step(0, 1'b0, 32'h0, 1'b1, 1'b0);
    nchk++; if (o_ack[0] !== 1'b1 || o_data[0] !== 32'h4040)
      $display("FAIL rm_queued got ack=%b %h want 1 00004040", o_ack[0], o_data[0]); else npass++;
    RST_N = 1'b0;
    #1;
    nchk++; if (o_ack[0] !== 1'b0 || c_ack[0] !== 1'b1 || o_data[0] !== 32'h0 || o_fd[0] !== 1'b0 || o_pa[0] !== 1'b0)
      $display("FAIL rm_reset_outputs got ack=%b core_ack=%b %h fd=%b pad=%b want 0 1 0 0 0",
               o_ack[0], c_ack[0], o_data[0], o_fd[0], o_pa[0]); else npass++;
    @(negedge CLK);
    RST_N = 1'b1;
    sent = 0; got = 0; cyc = 0;
    while (got < 120 && cyc < 600) begin
      step(0, sent < 120, 32'h4100 + sent, 1'b1, 1'b0);
      if (c_req[0] && c_ack[0]) sent++;
      if (o_ack[0] === 1'b1) begin
        nchk++;
        if (o_data[0] !== 32'h4100 + got || o_fd[0] !== (got == 119))
          $display("FAIL rm_beat %0d got %h fd=%b want %h fd=%b", got, o_data[0], o_fd[0], 32'h4100 + got, got == 119);
        else npass++;
        got++;
      end
      cyc++;
    end
    nchk++; if (got != 120) $display("FAIL rm_count got %0d want 120", got); else npass++;
  endtask

  task automatic test_no_timeout();
    int sent = 0, got = 0, cyc = 0;
    bit quiet = 1;
    while (got < 50 && cyc < 300) begin
      step(1, sent < 50, 32'h5000 + sent, 1'b1, 1'b0);
      if (c_req[1] && c_ack[1]) sent++;
      if (o_ack[1] === 1'b1) got++;
      cyc++;
    end
    for (int i = 0; i < 5000; i++) begin
      step(1, 1'b0, 32'h0, 1'b1, 1'b0);
      if (o_ack[1] !== 1'b0 || o_pa[1] !== 1'b0) quiet = 0;
    end
    nchk++; if (!quiet) $display("FAIL nt_stall got activity during stall want none"); else npass++;
    cyc = 0;
    while (got < 120 && cyc < 400) begin
      step(1, sent < 120, 32'h5000 + sent, 1'b1, 1'b0);
      if (c_req[1] && c_ack[1]) sent++;
      if (o_ack[1] === 1'b1) begin
        nchk++;
        if (o_data[1] !== 32'h5000 + got || o_fd[1] !== (got == 119) || o_pa[1] !== 1'b0)
          $display("FAIL nt_beat %0d got %h fd=%b want %h fd=%b", got, o_data[1], o_fd[1], 32'h5000 + got, got == 119);
        else npass++;
        got++;
      end
      cyc++;
    end
    nchk++; if (got != 120) $display("FAIL nt_count got %0d want 120", got); else npass++;
  endtask

`ifdef AHIR_TX_FRAMER_FLUSH_EN
  task automatic test_flush();
    int sent = 0, got = 0, cyc = 0, ndat = 0, npad = 0;
    while (got < 30 && cyc < 300) begin
      step(0, sent < 30, 32'h6000 + sent, 1'b1, 1'b0);
      if (c_req[0] && c_ack[0]) sent++;
      if (o_ack[0] === 1'b1) got++;
      cyc++;
    end
    for (int i = 0; i < 3; i++) step(0, 1'b1, 32'h6000 + 30 + i, 1'b0, 1'b0);
    step(0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc = 0;
    while (cyc < 300) begin
      step(0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (o_ack[0] === 1'b1) begin
        if (o_pa[0] === 1'b1) npad++;
        else begin
          nchk++;
          if (o_data[0] !== 32'h6000 + 30 + ndat) $display("FAIL fl_data got %h want %h", o_data[0], 32'h6000 + 30 + ndat);
          else npass++;
          ndat++;
        end
      end
      if (o_fd[0] === 1'b1) break;
      cyc++;
    end
    nchk++; if (ndat != 3 || npad != 87)
      $display("FAIL fl_counts got data=%0d pad=%0d want 3 87", ndat, npad); else npass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 2; i++) begin
      c_req[i] = 1'b0; c_data[i] = '0; o_req[i] = 1'b0;
    end
    flush_a = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_no_timeout();
`ifdef AHIR_TX_FRAMER_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
